// File: rtl/ysyx_23060221_wb_arbiter.sv
// Write-back arbiter: shares the register-file write port between EXU and LSU,
// holds one result for commit. Define YSYX_23060221_WBARB_LSU_PRIO_EN for fixed LSU priority.
module ysyx_23060221_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exu_valid,
    output logic              exu_ready,
    input  logic              exu_wen,
    input  logic [ADDR_W-1:0] exu_waddr,
    input  logic [DATA_W-1:0] exu_wdata,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_waddr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic              flush,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic              commit_src,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [31:0]       commit_cnt
);

    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } src_t;

    logic              valid_reg;
    src_t              src_reg;
    logic              wen_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [31:0]       cnt_reg;
`ifndef YSYX_23060221_WBARB_LSU_PRIO_EN
    src_t              last_reg;
`endif

    logic              slot_free;
    logic              accept_ok;
    logic              grant_lsu;
    logic              accept;
    logic              fire;
    logic              sel_wen;
    logic [ADDR_W-1:0] sel_waddr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        slot_free = !valid_reg | commit_ready;
        accept_ok = slot_free & !flush & rst_n;
`ifdef YSYX_23060221_WBARB_LSU_PRIO_EN
        grant_lsu = lsu_valid;
`else
        // On contention the source that did not win last time goes next.
        if (exu_valid & lsu_valid) begin
            grant_lsu = (last_reg == SRC_EXU);
        end else begin
            grant_lsu = lsu_valid;
        end
`endif
        accept    = accept_ok & (exu_valid | lsu_valid);
        exu_ready = accept_ok & exu_valid & !grant_lsu;
        lsu_ready = accept_ok & grant_lsu;
        fire      = valid_reg & commit_ready & !flush;
        sel_wen   = grant_lsu ? lsu_wen   : exu_wen;
        sel_waddr = grant_lsu ? lsu_waddr : exu_waddr;
        sel_wdata = grant_lsu ? lsu_wdata : exu_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            src_reg   <= SRC_EXU;
            wen_reg   <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= '0;
        end else if (accept) begin
            valid_reg <= 1'b1;
            src_reg   <= grant_lsu ? SRC_LSU : SRC_EXU;
            wen_reg   <= sel_wen;
            waddr_reg <= sel_waddr;
            wdata_reg <= sel_wdata;
        end else if (fire | flush) begin
            valid_reg <= 1'b0;
        end
    end

`ifndef YSYX_23060221_WBARB_LSU_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= SRC_LSU;
        end else if (accept) begin
            last_reg <= grant_lsu ? SRC_LSU : SRC_EXU;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 32'd0;
        end else if (fire) begin
            cnt_reg <= cnt_reg + 32'd1;
        end
    end

    // x0 writes retire and count but never reach the register file.
    assign rf_wen       = fire & wen_reg & (waddr_reg != '0) & rst_n;
    assign rf_waddr     = waddr_reg;
    assign rf_wdata     = wdata_reg;
    assign commit_valid = valid_reg;
    assign commit_src   = src_reg;
    assign commit_cnt   = cnt_reg;

endmodule

// File: tb/tb_ysyx_23060221_wb_arbiter.sv
// Bench for ysyx_23060221_wb_arbiter: slot/queue model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_ysyx_23060221_wb_arbiter;

`ifdef YSYX_23060221_WBARB_LSU_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exu_valid, exu_ready, exu_wen;
    logic [4:0]  exu_waddr;
    logic [31:0] exu_wdata;
    logic        lsu_valid, lsu_ready, lsu_wen;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        flush;
    logic        commit_valid, commit_ready, commit_src;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] commit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_23060221_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
        .exu_waddr(exu_waddr), .exu_wdata(exu_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
        .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
        .flush(flush),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_src(commit_src),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .commit_cnt(commit_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one-entry holding slot, a last-winner flag and a retired count.
    logic        m_valid, m_src, m_wen, m_last;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_cnt;
    logic [31:0] cnt_ofs = 32'd0;

    logic e_allow, e_win, e_exu_rdy, e_lsu_rdy, e_fire, e_rfwen;

    always_comb begin
        e_allow = (!m_valid || commit_ready) && !flush && (rst_n === 1'b1);
        if (exu_valid && lsu_valid) e_win = PRIO ? 1'b1 : !m_last;
        else                        e_win = lsu_valid;
        e_exu_rdy = e_allow && exu_valid && !e_win;
        e_lsu_rdy = e_allow && lsu_valid && e_win;
        e_fire    = m_valid && commit_ready && !flush;
        e_rfwen   = e_fire && m_wen && (m_addr != 5'd0) && (rst_n === 1'b1);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_src <= 1'b0; m_wen <= 1'b0; m_last <= 1'b1;
            m_addr  <= 5'd0; m_data <= 32'd0; m_cnt <= 32'd0;
        end else begin
            if (e_fire) m_cnt <= m_cnt + 32'd1;
            if (e_exu_rdy || e_lsu_rdy) begin
                m_valid <= 1'b1;
                m_src   <= e_win;
                m_last  <= e_win;
                m_wen   <= e_win ? lsu_wen   : exu_wen;
                m_addr  <= e_win ? lsu_waddr : exu_waddr;
                m_data  <= e_win ? lsu_wdata : exu_wdata;
            end else if (e_fire || flush) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("exu_ready",    {31'd0, exu_ready},    {31'd0, e_exu_rdy});
        chk("lsu_ready",    {31'd0, lsu_ready},    {31'd0, e_lsu_rdy});
        chk("commit_valid", {31'd0, commit_valid}, {31'd0, m_valid});
        chk("commit_src",   {31'd0, commit_src},   {31'd0, m_src});
        chk("rf_wen",       {31'd0, rf_wen},       {31'd0, e_rfwen});
        chk("rf_waddr",     {27'd0, rf_waddr},     {27'd0, m_addr});
        chk("rf_wdata",     rf_wdata,              m_data);
        chk("commit_cnt",   commit_cnt,            m_cnt + cnt_ofs);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] src_seq;

    initial begin
        rst_n = 1'b0; flush = 1'b0; commit_ready = 1'b1;
        exu_valid = 1'b1; exu_wen = 1'b0; exu_waddr = 5'd0; exu_wdata = 32'd0;
        lsu_valid = 1'b0; lsu_wen = 1'b0; lsu_waddr = 5'd0; lsu_wdata = 32'd0;
        src_seq = PRIO ? 4'b1111 : 4'b1010;
        repeat (2) cyc();
        #1;
        chk("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
        chk("rst_exu_ready",    {31'd0, exu_ready},    32'd0);
        chk("rst_rf_wen",       {31'd0, rf_wen},       32'd0);
        chk("rst_commit_cnt",   commit_cnt,            32'd0);

        // Single EXU result
        cyc();
        rst_n = 1'b1; exu_valid = 1'b1; exu_wen = 1'b1; exu_waddr = 5'd5; exu_wdata = 32'h1234;
        #1 chk("t1_exu_ready", {31'd0, exu_ready}, 32'd1);
        cyc(); exu_valid = 1'b0;
        #1;
        chk("t1_rf_wen",   {31'd0, rf_wen}, 32'd1);
        chk("t1_rf_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("t1_rf_wdata", rf_wdata, 32'h1234);
        cyc();
        #1;
        chk("t1_cnt",   commit_cnt, 32'd1);
        chk("t1_empty", {31'd0, commit_valid}, 32'd0);

        // Contention from a fresh reset
        rst_n = 1'b0; cnt_ofs = 32'd0;
        cyc();
        rst_n = 1'b1;
        exu_valid = 1'b1; exu_wen = 1'b1; exu_waddr = 5'd1; exu_wdata = 32'hA0;
        lsu_valid = 1'b1; lsu_wen = 1'b1; lsu_waddr = 5'd2; lsu_wdata = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            exu_wdata = 32'hA1 + i; lsu_wdata = 32'hB1 + i;
            #1 chk($sformatf("t2_src%0d", i), {31'd0, commit_src}, {31'd0, src_seq[i]});
        end

        // Stall with LSU waiting
        exu_valid = 1'b0; lsu_waddr = 5'd7; lsu_wdata = 32'hC0; commit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk($sformatf("t3_lsu_ready%0d", i), {31'd0, lsu_ready}, 32'd0);
            chk($sformatf("t3_rf_wen%0d", i),    {31'd0, rf_wen},    32'd0);
        end
        commit_ready = 1'b1;
        #1;
        chk("t3_lsu_ready_go", {31'd0, lsu_ready}, 32'd1);
        chk("t3_rf_wen_go",    {31'd0, rf_wen},    32'd1);
        cyc(); lsu_valid = 1'b0;
        #1;
        chk("t3_src",   {31'd0, commit_src}, 32'd1);
        chk("t3_wdata", rf_wdata, 32'hC0);
        chk("t3_cnt",   commit_cnt, 32'd4);

        // Write to x0
        exu_valid = 1'b1; exu_wen = 1'b1; exu_waddr = 5'd0; exu_wdata = 32'hDEAD;
        cyc(); exu_valid = 1'b0;
        #1;
        chk("t4_valid",  {31'd0, commit_valid}, 32'd1);
        chk("t4_rf_wen", {31'd0, rf_wen}, 32'd0);
        chk("t4_cnt0",   commit_cnt, 32'd5);
        cyc();
        #1 chk("t4_cnt1", commit_cnt, 32'd6);

        // Flush a full slot
        exu_valid = 1'b1; exu_waddr = 5'd9; exu_wdata = 32'h99;
        cyc();
        exu_wdata = 32'h77; flush = 1'b1;
        #1;
        chk("t5_rf_wen",    {31'd0, rf_wen},    32'd0);
        chk("t5_exu_ready", {31'd0, exu_ready}, 32'd0);
        cyc(); flush = 1'b0; exu_valid = 1'b0;
        #1;
        chk("t5_valid", {31'd0, commit_valid}, 32'd0);
        chk("t5_cnt",   commit_cnt, 32'd6);

        // Counter wrap
        force dut.cnt_reg = 32'hFFFF_FFFF;
        cnt_ofs = 32'hFFFF_FFFF - m_cnt;
        exu_valid = 1'b1; exu_waddr = 5'd3; exu_wdata = 32'h55;
        #1 release dut.cnt_reg;
        #1 chk("t6_preset", commit_cnt, 32'hFFFF_FFFF);
        cyc(); exu_valid = 1'b0;
        cyc();
        #1 chk("t6_wrap", commit_cnt, 32'd0);

        // Asynchronous reset with a full slot
        exu_valid = 1'b1; exu_waddr = 5'd4; exu_wdata = 32'h66;
        cyc();
        rst_n = 1'b0; cnt_ofs = 32'd0;
        #1;
        chk("t7_valid",     {31'd0, commit_valid}, 32'd0);
        chk("t7_exu_ready", {31'd0, exu_ready},    32'd0);
        chk("t7_rf_wen",    {31'd0, rf_wen},       32'd0);
        chk("t7_cnt",       commit_cnt,            32'd0);
        chk("t7_waddr",     {27'd0, rf_waddr},     32'd0);
        chk("t7_wdata",     rf_wdata,              32'd0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
